// File: rtl/apb_bridge_if.sv
// Bus bundle between the RV32I memory stage, the bridge and the APB slaves.
// The bridge takes the master modport (it masters APB and answers the core);
// the environment (core model plus slaves) takes the slave modport.
interface apb_bridge_if #(
   parameter int NUM_SLV = 4
);
   logic                    transEn;
   logic                    proc_write;
   logic [31:0]             proc_addr;
   logic [31:0]             proc_wdata;
   logic [31:0]             proc_rdata;
   logic                    proc_ready;
   logic                    PENABLE;
   logic [NUM_SLV-1:0]      PSEL;
   logic [31:0]             PADDR;
   logic                    PWRITE;
   logic [31:0]             PWDATA;
   logic [32*NUM_SLV-1:0]   PRDATA;
   logic [NUM_SLV-1:0]      PREADY;
   logic [NUM_SLV-1:0]      PSLVERR;
   logic                    bus_err;

   modport master (
      input  transEn, proc_write, proc_addr, proc_wdata,
      input  PRDATA, PREADY, PSLVERR,
      output proc_rdata, proc_ready, PENABLE, PSEL, PADDR, PWRITE, PWDATA,
      output bus_err
   );

   modport slave (
      output transEn, proc_write, proc_addr, proc_wdata,
      output PRDATA, PREADY, PSLVERR,
      input  proc_rdata, proc_ready, PENABLE, PSEL, PADDR, PWRITE, PWDATA,
      input  bus_err
   );
endinterface

// File: rtl/apb_bridge.sv
// APB3 bridge for the RV32I memory stage: decodes the slave from an address
// field, runs SETUP/ACCESS, bounds wait states with a timeout and keeps a
// sticky error flag.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | no transfer; request latched when transEn is high
//   S_SETUP   | PSEL driven, PENABLE low (one cycle)
//   S_ACCESS  | PENABLE high, waiting on PREADY of the selected slave
//   S_ERRDONE | decode miss, complete with ERR_DATA in one cycle
module apb_bridge #(
   parameter int          NUM_SLV  = 4,
   parameter int          SEL_LSB  = 12,
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input logic          clk,
   input logic          rst,
   apb_bridge_if.master bus
);

   localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_ERRDONE
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_SLV-1:0]   psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic [31:0]          paddr_q, paddr_d;
   logic                 pwrite_q, pwrite_d;
   logic [31:0]          pwdata_q, pwdata_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 bus_err_q, bus_err_d;
   logic [IDX_W-1:0]     idx_q, idx_d;

   logic [IDX_W-1:0]     sel_field;
   logic                 sel_in_range;
   logic                 pready_sel;
   logic                 pslverr_sel;
   logic [31:0]          prdata_sel;
   logic                 timeout_hit;
   logic                 ready_c;
   logic [31:0]          rdata_c;

   // Slave-select field of the incoming address; a single slave needs no field.
   always_comb begin
      sel_field = '0;
      if (NUM_SLV > 1) begin
         sel_field = bus.proc_addr[SEL_LSB +: IDX_W];
      end
   end

   assign sel_in_range = (32'(sel_field) < 32'(NUM_SLV));
   assign pready_sel   = bus.PREADY[idx_q];
   assign pslverr_sel  = bus.PSLVERR[idx_q];
   assign prdata_sel   = bus.PRDATA[32*int'(idx_q) +: 32];
   assign timeout_hit  = (cnt_q == 8'(TIMEOUT - 1));

   // Next-state, latch updates and the combinational completion response.
   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      cnt_d     = cnt_q;
      bus_err_d = bus_err_q;
      idx_d     = idx_q;
      ready_c   = 1'b0;
      rdata_c   = 32'h0;

      case (state_q)
         S_IDLE: begin
            if (bus.transEn) begin
               paddr_d  = bus.proc_addr;
               pwrite_d = bus.proc_write;
               pwdata_d = bus.proc_wdata;
               idx_d    = sel_field;
               if (sel_in_range) begin
                  psel_d  = NUM_SLV'(1) << sel_field;
                  state_d = S_SETUP;
               end else begin
                  state_d = S_ERRDONE;
               end
            end
         end

         S_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = 8'd0;
            state_d   = S_ACCESS;
         end

         S_ACCESS: begin
            if (pready_sel) begin
               ready_c   = 1'b1;
               rdata_c   = pwrite_q ? 32'h0 : prdata_sel;
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = S_IDLE;
               if (pslverr_sel) begin
                  bus_err_d = 1'b1;
               end
            end else if (timeout_hit) begin
               // Forced completion; any later PREADY from this slave is dropped.
               ready_c   = 1'b1;
               rdata_c   = pwrite_q ? 32'h0 : ERR_DATA;
               bus_err_d = 1'b1;
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_ERRDONE: begin
            ready_c   = 1'b1;
            rdata_c   = pwrite_q ? 32'h0 : ERR_DATA;
            bus_err_d = 1'b1;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, APB latches, wait counter and sticky error; reset drops any transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         psel_q    <= '0;
         penable_q <= 1'b0;
         paddr_q   <= 32'h0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= 32'h0;
         cnt_q     <= 8'd0;
         bus_err_q <= 1'b0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
         idx_q     <= idx_d;
      end
   end

   assign bus.proc_ready = ready_c & ~rst;
   assign bus.proc_rdata = rst ? 32'h0 : rdata_c;
   assign bus.PENABLE    = penable_q;
   assign bus.PSEL       = psel_q;
   assign bus.PADDR      = paddr_q;
   assign bus.PWRITE     = pwrite_q;
   assign bus.PWDATA     = pwdata_q;
   assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_apb_bridge.sv
// Bench for apb_bridge: transaction-level expectations per cycle, random
// traffic with random wait states and slave errors, plus literal pins.
module tb_apb_bridge;

   localparam int          NS   = 4;
   localparam int          TO   = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apb_bridge_if #(.NUM_SLV(NS)) bus();

   apb_bridge #(
      .NUM_SLV  (NS),
      .SEL_LSB  (12),
      .TIMEOUT  (TO),
      .ERR_DATA (ERRD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   // expected per-cycle view of the outputs
   logic [NS-1:0] e_psel;
   logic          e_pen;
   logic          e_rdy;
   logic [31:0]   e_rdata;
   logic [31:0]   e_paddr;
   logic          e_pwrite;
   logic [31:0]   e_pwdata;
   logic          e_err;
   bit            chk_en = 0;

   int          rdy_cyc[$];
   logic [31:0] rdy_data[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // per-cycle compare against the expected view
   always @(negedge clk) begin
      if (chk_en) begin
         chk("psel",    32'(bus.PSEL),       32'(e_psel));
         chk("penable", 32'(bus.PENABLE),    32'(e_pen));
         chk("ready",   32'(bus.proc_ready), 32'(e_rdy));
         chk("bus_err", 32'(bus.bus_err),    32'(e_err));
         if (e_rdy) chk("rdata", bus.proc_rdata, e_rdata);
         if (e_psel != '0) begin
            chk("paddr",  bus.PADDR,         e_paddr);
            chk("pwrite", 32'(bus.PWRITE),   32'(e_pwrite));
            chk("pwdata", bus.PWDATA,        e_pwdata);
         end
         if (bus.proc_ready === 1'b1) begin
            rdy_cyc.push_back(cyc);
            rdy_data.push_back(bus.proc_rdata);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_slaves();
      bus.PREADY  = NS'($urandom);
      bus.PSLVERR = NS'($urandom);
      for (int i = 0; i < NS; i++) bus.PRDATA[32*i +: 32] = $urandom;
   endtask

   task automatic junk_proc();
      bus.proc_write = 1'($urandom);
      bus.proc_addr  = $urandom;
      bus.proc_wdata = $urandom;
   endtask

   task automatic idle_exp();
      e_psel = '0;
      e_pen  = 1'b0;
      e_rdy  = 1'b0;
   endtask

   task automatic idle_cycle();
      rand_slaves();
      junk_proc();
      bus.transEn = 1'b0;
      idle_exp();
      tick();
   endtask

   // One transfer. Called in an IDLE cycle; returns in the IDLE cycle after
   // completion. w = cycles PREADY stays low (>= TO means it never comes).
   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int w, input logic perr, input logic [31:0] rd,
                          output int c0);
      int     slv;
      int     last;
      bit     tout;
      slv  = int'((addr >> 12) % NS);
      tout = (w >= TO);
      last = tout ? TO - 1 : w;
      c0   = cyc;
      rand_slaves();
      idle_exp();
      bus.transEn    = 1'b1;
      bus.proc_write = wr;
      bus.proc_addr  = addr;
      bus.proc_wdata = wdata;
      tick();
      // setup
      rand_slaves();
      junk_proc();
      bus.transEn = 1'($urandom);
      e_psel   = NS'(1) << slv;
      e_pen    = 1'b0;
      e_rdy    = 1'b0;
      e_paddr  = addr;
      e_pwrite = wr;
      e_pwdata = wdata;
      tick();
      // access
      for (int k = 0; k <= last; k++) begin
         rand_slaves();
         junk_proc();
         bus.transEn = 1'($urandom);
         bus.PREADY[slv]  = (k == w);
         bus.PSLVERR[slv] = (k == w) ? perr : 1'($urandom);
         bus.PRDATA[32*slv +: 32] = rd;
         e_pen = 1'b1;
         e_rdy = (k == last);
         e_rdata = wr ? 32'h0 : (tout ? ERRD : rd);
         tick();
      end
      if (tout || perr) e_err = 1'b1;
      idle_exp();
      bus.transEn = 1'b0;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      rand_slaves();
      bus.transEn = 1'b0;
      idle_exp();
      tick();
      rst   = 1'b0;
      e_err = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1;
      logic wr, perr;
      logic [31:0] a;
      int w;

      rst = 1'b1;
      bus.transEn    = 1'b0;
      bus.proc_write = 1'b0;
      bus.proc_addr  = 32'h0;
      bus.proc_wdata = 32'h0;
      bus.PREADY     = '0;
      bus.PSLVERR    = '0;
      bus.PRDATA     = '0;
      idle_exp();
      e_err = 1'b0;
      e_rdata = 32'h0;
      e_paddr = 32'h0;
      e_pwrite = 1'b0;
      e_pwdata = 32'h0;
      tick();
      tick();
      chk("rst_psel",   32'(bus.PSEL),       32'h0);
      chk("rst_pen",    32'(bus.PENABLE),    32'h0);
      chk("rst_paddr",  bus.PADDR,           32'h0);
      chk("rst_pwdata", bus.PWDATA,          32'h0);
      chk("rst_pwrite", 32'(bus.PWRITE),     32'h0);
      chk("rst_ready",  32'(bus.proc_ready), 32'h0);
      chk("rst_rdata",  bus.proc_rdata,      32'h0);
      chk("rst_err",    32'(bus.bus_err),    32'h0);
      rst = 1'b0;
      chk_en = 1;
      idle_cycle();

      // zero-wait read of slave 1
      do_xfer(1'b0, 32'h0000_1004, 32'h0, 0, 1'b0, 32'h1234_5678, c0);
      chk("zw_lat",   32'(rdy_cyc[$] - c0), 32'd2);
      chk("zw_rdata", rdy_data[$],          32'h1234_5678);
      chk("zw_err",   32'(bus.bus_err),     32'h0);
      idle_cycle();

      // write with three wait states to slave 3
      do_xfer(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 3, 1'b0, 32'h5555_AAAA, c0);
      chk("w3_lat",   32'(rdy_cyc[$] - c0), 32'd5);
      chk("w3_rdata", rdy_data[$],          32'h0);
      idle_cycle();

      // timeout on slave 0
      do_xfer(1'b0, 32'h0000_0000, 32'h0, 100, 1'b0, 32'h0BAD_0BAD, c0);
      chk("to_lat",   32'(rdy_cyc[$] - c0), 32'd5);
      chk("to_rdata", rdy_data[$],          32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) idle_cycle();
      chk("to_sticky", 32'(bus.bus_err), 32'h1);
      rst_pulse();
      idle_cycle();
      chk("err_clr", 32'(bus.bus_err), 32'h0);

      // slave error on slave 2
      do_xfer(1'b0, 32'h0000_2000, 32'h0, 0, 1'b1, 32'h0000_00AA, c0);
      chk("se_rdata", rdy_data[$],      32'h0000_00AA);
      chk("se_err",   32'(bus.bus_err), 32'h1);
      rst_pulse();
      idle_cycle();

      // back-to-back reads, transEn held high
      do_xfer(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 32'h1111_0000, c0);
      do_xfer(1'b0, 32'h0000_1010, 32'h0, 0, 1'b0, 32'h2222_0001, c1);
      chk("b2b_gap",  32'(rdy_cyc[$] - rdy_cyc[$-1]), 32'd3);
      chk("b2b_data", rdy_data[$],                    32'h2222_0001);
      idle_cycle();

      // reset in the middle of ACCESS
      rand_slaves();
      bus.transEn    = 1'b1;
      bus.proc_write = 1'b0;
      bus.proc_addr  = 32'h0000_1000;
      tick();
      bus.transEn = 1'b0;
      bus.PREADY  = '0;
      e_psel = 4'b0010; e_pen = 1'b0; e_paddr = 32'h0000_1000; e_pwrite = 1'b0;
      e_pwdata = bus.proc_wdata;
      tick();
      bus.PREADY = '0;
      e_pen = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_exp();
      e_err = 1'b0;
      chk("ab_psel",  32'(bus.PSEL),    32'h0);
      chk("ab_pen",   32'(bus.PENABLE), 32'h0);
      chk("ab_err",   32'(bus.bus_err), 32'h0);
      idle_cycle();
      do_xfer(1'b0, 32'h0000_1008, 32'h0, 1, 1'b0, 32'h7777_8888, c0);
      chk("ab_next", rdy_data[$], 32'h7777_8888);
      chk("ab_lat",  32'(rdy_cyc[$] - c0), 32'd3);

      // random traffic
      for (int n = 0; n < 200; n++) begin
         wr   = 1'($urandom);
         a    = $urandom;
         w    = $urandom_range(0, 6);
         perr = ($urandom_range(0, 7) == 0);
         do_xfer(wr, a, $urandom, w, perr, $urandom, c0);
         repeat ($urandom_range(0, 2)) idle_cycle();
         if (n % 50 == 49) rst_pulse();
      end
      idle_cycle();

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
